i2s_clkgen: RTL and testbench

Parametrised, runtime-programmable clock generator for the I2S path. It divides the system clock into a 50 % duty-cycle bit clock (bclk) with a loadable half-period. From bclk falling edges it derives the word-select clock (ws). Single-cycle strobes are aligned to every bclk/ws edge so that downstream serialisers can run on clk without using bclk as a clock.

---
 rtl/i2s_clkgen.sv | 116 +++++++++++
 tb/tb_i2s_clkgen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/i2s_clkgen.sv
// I2S clock generator: divides clk into a 50 % bclk with a loadable half-period,
// derives ws from bclk falling edges and emits clk-aligned edge strobes.
module i2s_clkgen #(
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 2666,
  parameter int SLOT_W   = 6,
  parameter int DEF_SLOT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CNT_W-1:0]  half_div,
  input  logic              div_load,
  input  logic [SLOT_W-1:0] slot_bits,
  output logic              bclk,
  output logic              ws,
  output logic              bclk_rise,
  output logic              bclk_fall,
  output logic              ws_edge,
  output logic              frame_start
);

  localparam logic [CNT_W-1:0]  DEF_HALF_C = (DEF_HALF == 0) ? CNT_W'(1) : CNT_W'(DEF_HALF);
  localparam logic [SLOT_W-1:0] DEF_SLOT_C = (DEF_SLOT == 0) ? SLOT_W'(1) : SLOT_W'(DEF_SLOT);

  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  half_reg;
  logic [CNT_W-1:0]  pend_reg;
  logic              pend_valid_reg;
  logic [SLOT_W-1:0] bit_cnt_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic              bclk_reg;
  logic              ws_reg;
  logic              bclk_rise_reg;
  logic              bclk_fall_reg;
  logic              ws_edge_reg;
  logic              frame_start_reg;

  logic [CNT_W-1:0]  half_div_c;
  logic [SLOT_W-1:0] slot_bits_c;
  logic [CNT_W-1:0]  eff_half;
  logic              boundary;
  logic              slot_wrap;

  always_comb begin
    half_div_c  = (half_div == '0) ? CNT_W'(1) : half_div;
    slot_bits_c = (slot_bits == '0) ? SLOT_W'(1) : slot_bits;
    boundary    = en && (cnt_reg == '0);
    // A load arriving on the boundary itself wins over an older pending value.
    if (div_load)
      eff_half = half_div_c;
    else if (pend_valid_reg)
      eff_half = pend_reg;
    else
      eff_half = half_reg;
    slot_wrap = (bit_cnt_reg == slot_reg - SLOT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg         <= DEF_HALF_C - CNT_W'(1);
      half_reg        <= DEF_HALF_C;
      pend_reg        <= DEF_HALF_C;
      pend_valid_reg  <= 1'b0;
      bit_cnt_reg     <= '0;
      slot_reg        <= DEF_SLOT_C;
      bclk_reg        <= 1'b0;
      ws_reg          <= 1'b0;
      bclk_rise_reg   <= 1'b0;
      bclk_fall_reg   <= 1'b0;
      ws_edge_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      bclk_rise_reg   <= 1'b0;
      bclk_fall_reg   <= 1'b0;
      ws_edge_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      if (div_load && !boundary) begin
        pend_reg       <= half_div_c;
        pend_valid_reg <= 1'b1;
      end
      if (en) begin
        if (boundary) begin
          half_reg       <= eff_half;
          pend_valid_reg <= 1'b0;
          cnt_reg        <= eff_half - CNT_W'(1);
          bclk_reg       <= ~bclk_reg;
          bclk_rise_reg  <= ~bclk_reg;
          bclk_fall_reg  <= bclk_reg;
          // ws advances only on bclk falling boundaries.
          if (bclk_reg) begin
            if (slot_wrap) begin
              ws_reg          <= ~ws_reg;
              ws_edge_reg     <= 1'b1;
              frame_start_reg <= ws_reg;
              bit_cnt_reg     <= '0;
              slot_reg        <= slot_bits_c;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + SLOT_W'(1);
            end
          end
        end else begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end
    end
  end

  assign bclk        = bclk_reg;
  assign ws          = ws_reg;
  assign bclk_rise   = bclk_rise_reg;
  assign bclk_fall   = bclk_fall_reg;
  assign ws_edge     = ws_edge_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_i2s_clkgen.sv
// Randomized bench for i2s_clkgen against a level-duration reference model.
module tb_i2s_clkgen;

  localparam int CNT_W  = 8;
  localparam int SLOT_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [CNT_W-1:0]  half_div;
  logic              div_load;
  logic [SLOT_W-1:0] slot_bits;
  logic              bclk, ws, bclk_rise, bclk_fall, ws_edge, frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  i2s_clkgen #(.CNT_W(CNT_W), .DEF_HALF(4), .SLOT_W(SLOT_W), .DEF_SLOT(2)) dut (
    .clk(clk), .reset(reset), .en(en), .half_div(half_div), .div_load(div_load),
    .slot_bits(slot_bits), .bclk(bclk), .ws(ws), .bclk_rise(bclk_rise),
    .bclk_fall(bclk_fall), .ws_edge(ws_edge), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: each bclk level lasts m_half enabled cycles (m_age counts
  // cycles already shown at the current level); each ws level lasts m_slot falls.
  bit m_init = 0;
  int m_half, m_age, m_pend, m_slot, m_falls;
  bit m_pend_v, m_bclk, m_ws, m_rise, m_fall, m_wse, m_fs;

  function automatic int at_least_1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clock();
    m_rise = 0; m_fall = 0; m_wse = 0; m_fs = 0;
    if (reset) begin
      m_init = 1; m_half = 4; m_age = 1; m_pend_v = 0;
      m_slot = 2; m_falls = 0; m_bclk = 0; m_ws = 0;
    end else if (!en) begin
      if (div_load) begin m_pend = at_least_1(int'(half_div)); m_pend_v = 1; end
    end else if (m_age == m_half) begin
      if (div_load) m_half = at_least_1(int'(half_div));
      else if (m_pend_v) m_half = m_pend;
      m_pend_v = 0;
      m_age = 1;
      m_bclk = !m_bclk;
      if (m_bclk) m_rise = 1;
      else begin
        m_fall = 1;
        m_falls++;
        if (m_falls == m_slot) begin
          m_ws = !m_ws; m_wse = 1; m_fs = !m_ws;
          m_falls = 0; m_slot = at_least_1(int'(slot_bits));
        end
      end
    end else begin
      m_age++;
      if (div_load) begin m_pend = at_least_1(int'(half_div)); m_pend_v = 1; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    if (reset) cyc = 0; else cyc++;
    if (m_init) begin
      check_value("bclk", bclk, m_bclk);
      check_value("ws", ws, m_ws);
      check_value("bclk_rise", bclk_rise, m_rise);
      check_value("bclk_fall", bclk_fall, m_fall);
      check_value("ws_edge", ws_edge, m_wse);
      check_value("frame_start", frame_start, m_fs);
    end
  endtask

  initial begin
    int t_rise, t_fall, t_ws, t_fs;
    t_rise = -1; t_fall = -1; t_ws = -1; t_fs = -1;
    reset = 1; en = 0; half_div = '0; div_load = 0; slot_bits = 6'd2;
    step();
    step();
    reset = 0; en = 1;
    // Free-running from reset with the default divisor and slot length.
    for (int i = 0; i < 40; i++) begin
      step();
      if (bclk_rise && t_rise < 0) t_rise = cyc;
      if (bclk_fall && t_fall < 0) t_fall = cyc;
      if (ws_edge && t_ws < 0) t_ws = cyc;
      if (frame_start && t_fs < 0) t_fs = cyc;
    end
    check_value("first_rise", t_rise, 4);
    check_value("first_fall", t_fall, 8);
    check_value("first_ws_edge", t_ws, 16);
    check_value("first_frame_start", t_fs, 32);

    // Load to half_div=0 while held in reset-free run: bclk must toggle every cycle.
    half_div = '0; div_load = 1; slot_bits = '0;
    step();
    div_load = 0;
    for (int i = 0; i < 20; i++) step();

    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      en        = ($urandom_range(0, 9) != 0);
      div_load  = ($urandom_range(0, 11) == 0);
      half_div  = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) slot_bits = SLOT_W'($urandom_range(0, 4));
      step();
    end

    // Reset mid-operation with a pending load: defaults must come back.
    reset = 0; en = 1; half_div = 8'd2; div_load = 1;
    step();
    div_load = 0; reset = 1;
    step();
    check_value("rst_bclk", bclk, 1'b0);
    check_value("rst_ws", ws, 1'b0);
    reset = 0;
    t_rise = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bclk_rise && t_rise < 0) t_rise = cyc;
    end
    check_value("rst_first_rise", t_rise, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
